// File: rtl/edge_frame_decoder.sv
// Rising-edge serial frame decoder: sync preamble, duration-compared metadata bits,
// then a metadata-sized scan phase that alternates coil polarity on every edge.
module edge_frame_decoder #(
    parameter int CLK_PER_MS     = 10000,
    parameter int TIMEOUT_MS     = 1000,
    parameter int PREAMBLE_EDGES = 3,
    parameter int META_BITS      = 4,
    parameter int CNT_W          = 12
) (
    input  logic                 CLK_IN,
    input  logic                 rst,
    input  logic                 DATA_IN,
    output logic [META_BITS-1:0] meta_out,
    output logic                 meta_valid,
    output logic                 scan_active,
    output logic                 coil_pos,
    output logic                 coil_neg,
    output logic                 timeout_err,
    output logic [3:0]           state_out
);

    localparam int TICK_W = $clog2(CLK_PER_MS + 1);
    localparam int MS_W   = $clog2(TIMEOUT_MS + 1);
    localparam int EC_W   = $clog2(PREAMBLE_EDGES + 1);
    localparam int BI_W   = (META_BITS > 1) ? $clog2(META_BITS) : 1;
    localparam int SR_W   = META_BITS + 2;
    localparam logic signed [CNT_W-1:0] ACC_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] ACC_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        PREAMBLE  = 4'd1,
        DATA_WAIT = 4'd3,
        ADD       = 4'd4,
        SUB       = 4'd5,
        END_BIT   = 4'd6,
        WAIT_SCAN = 4'd7,
        SEND_POS  = 4'd8,
        SEND_NEG  = 4'd9
    } state_t;

    state_t                  state_reg, state_next;
    logic [2:0]              sync_reg;
    logic [TICK_W-1:0]       tick_cnt_reg;
    logic [MS_W-1:0]         ms_cnt_reg, ms_cnt_next;
    logic [EC_W-1:0]         edge_cnt_reg, edge_cnt_next;
    logic [BI_W-1:0]         bit_idx_reg, bit_idx_next;
    logic [META_BITS-1:0]    shreg_reg, shreg_next, word_next;
    logic signed [CNT_W-1:0] acc_reg, acc_next;
    logic [SR_W-1:0]         scan_rem_reg, scan_rem_next, scan_rem_dec;
    logic [META_BITS-1:0]    meta_out_reg, meta_out_next;
    logic                    meta_valid_reg, meta_valid_next;
    logic                    timeout_reg, timeout_next;
    logic                    scan_active_reg, coil_pos_reg, coil_neg_reg;
    logic                    edge_det, tick, bit_val, timeout_hit;

    assign edge_det     = sync_reg[1] & ~sync_reg[2];
    assign tick         = (tick_cnt_reg == TICK_W'(CLK_PER_MS - 1));
    assign bit_val      = !acc_reg[CNT_W-1] && (acc_reg != '0);
    assign scan_rem_dec = scan_rem_reg - SR_W'(1);
    assign timeout_hit  = (state_reg != IDLE) && (ms_cnt_reg == MS_W'(TIMEOUT_MS)) && !edge_det;

    // Current shift register with the bit being closed out dropped into its slot.
    generate
        for (genvar gi = 0; gi < META_BITS; gi++) begin : g_word
            assign word_next[gi] = (bit_idx_reg == BI_W'(gi)) ? bit_val : shreg_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        edge_cnt_next   = edge_cnt_reg;
        bit_idx_next    = bit_idx_reg;
        shreg_next      = shreg_reg;
        acc_next        = acc_reg;
        scan_rem_next   = scan_rem_reg;
        meta_out_next   = meta_out_reg;
        meta_valid_next = 1'b0;
        timeout_next    = 1'b0;
        ms_cnt_next     = ms_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (edge_det) begin
                    state_next    = PREAMBLE;
                    edge_cnt_next = EC_W'(1);
                end
            end
            PREAMBLE: begin
                if (edge_det) begin
                    edge_cnt_next = edge_cnt_reg + EC_W'(1);
                    if (edge_cnt_reg + EC_W'(1) == EC_W'(PREAMBLE_EDGES))
                        state_next = DATA_WAIT;
                end
            end
            DATA_WAIT: begin
                bit_idx_next = '0;
                shreg_next   = '0;
                if (edge_det) begin
                    state_next = ADD;
                    acc_next   = '0;
                end
            end
            ADD: begin
                if (acc_reg != ACC_MAX)
                    acc_next = acc_reg + CNT_W'(1);
                if (edge_det)
                    state_next = SUB;
            end
            SUB: begin
                if (acc_reg != ACC_MIN)
                    acc_next = acc_reg - CNT_W'(1);
                if (edge_det)
                    state_next = END_BIT;
            end
            END_BIT: begin
                shreg_next = word_next;
                if (bit_idx_reg == BI_W'(META_BITS - 1)) begin
                    meta_out_next   = word_next;
                    meta_valid_next = 1'b1;
                    scan_rem_next   = (SR_W'(word_next) + SR_W'(1)) << 1;
                    state_next      = WAIT_SCAN;
                end else begin
                    bit_idx_next = bit_idx_reg + BI_W'(1);
                    // An edge here already belongs to the next bit's high phase.
                    if (edge_det) begin
                        state_next = SUB;
                        acc_next   = CNT_W'(1);
                    end else begin
                        state_next = ADD;
                        acc_next   = '0;
                    end
                end
            end
            WAIT_SCAN: begin
                if (edge_det)
                    state_next = SEND_POS;
            end
            SEND_POS, SEND_NEG: begin
                if (edge_det) begin
                    scan_rem_next = scan_rem_dec;
                    if (scan_rem_dec == '0)
                        state_next = IDLE;
                    else
                        state_next = (state_reg == SEND_POS) ? SEND_NEG : SEND_POS;
                end
            end
            default: state_next = IDLE;
        endcase

        if (timeout_hit) begin
            state_next   = IDLE;
            timeout_next = 1'b1;
        end

        if (edge_det || (state_next != state_reg))
            ms_cnt_next = '0;
        else if (tick && (ms_cnt_reg != MS_W'(TIMEOUT_MS)))
            ms_cnt_next = ms_cnt_reg + MS_W'(1);
    end

    always_ff @(posedge CLK_IN) begin
        if (rst) begin
            state_reg       <= IDLE;
            sync_reg        <= '0;
            tick_cnt_reg    <= '0;
            ms_cnt_reg      <= '0;
            edge_cnt_reg    <= '0;
            bit_idx_reg     <= '0;
            shreg_reg       <= '0;
            acc_reg         <= '0;
            scan_rem_reg    <= '0;
            meta_out_reg    <= '0;
            meta_valid_reg  <= 1'b0;
            timeout_reg     <= 1'b0;
            scan_active_reg <= 1'b0;
            coil_pos_reg    <= 1'b0;
            coil_neg_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sync_reg        <= {sync_reg[1:0], DATA_IN};
            tick_cnt_reg    <= tick ? '0 : tick_cnt_reg + TICK_W'(1);
            ms_cnt_reg      <= ms_cnt_next;
            edge_cnt_reg    <= edge_cnt_next;
            bit_idx_reg     <= bit_idx_next;
            shreg_reg       <= shreg_next;
            acc_reg         <= acc_next;
            scan_rem_reg    <= scan_rem_next;
            meta_out_reg    <= meta_out_next;
            meta_valid_reg  <= meta_valid_next;
            timeout_reg     <= timeout_next;
            scan_active_reg <= (state_next == WAIT_SCAN) || (state_next == SEND_POS) ||
                               (state_next == SEND_NEG);
            coil_pos_reg    <= (state_next == SEND_POS);
            coil_neg_reg    <= (state_next == SEND_NEG);
        end
    end

    assign meta_out    = meta_out_reg;
    assign meta_valid  = meta_valid_reg;
    assign scan_active = scan_active_reg;
    assign coil_pos    = coil_pos_reg;
    assign coil_neg    = coil_neg_reg;
    assign timeout_err = timeout_reg;
    assign state_out   = state_reg;

endmodule

// File: tb/tb_edge_frame_decoder.sv
// Directed bench for edge_frame_decoder: frame decode, scan, timeout, saturation, reset.
module tb_edge_frame_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_a, din_b;
    logic [3:0] meta_a, meta_b, state_a, state_b;
    logic       mv_a, scan_a, pos_a, neg_a, to_a;
    logic       mv_b, scan_b, pos_b, neg_b, to_b;

    int errs   = 0;
    int checks = 0;
    int mv_cnt = 0;
    int to_cnt = 0;
    int overlap = 0;
    logic [3:0] mv_val = '0;

    always #5 clk = ~clk;

    edge_frame_decoder #(.CLK_PER_MS(10), .TIMEOUT_MS(5)) dut (
        .CLK_IN(clk), .rst(rst), .DATA_IN(din_a),
        .meta_out(meta_a), .meta_valid(mv_a), .scan_active(scan_a),
        .coil_pos(pos_a), .coil_neg(neg_a), .timeout_err(to_a), .state_out(state_a)
    );

    // Long timeout so multi-thousand-cycle phases can reach accumulator saturation.
    edge_frame_decoder #(.CLK_PER_MS(10), .TIMEOUT_MS(1000)) dut_sat (
        .CLK_IN(clk), .rst(rst), .DATA_IN(din_b),
        .meta_out(meta_b), .meta_valid(mv_b), .scan_active(scan_b),
        .coil_pos(pos_b), .coil_neg(neg_b), .timeout_err(to_b), .state_out(state_b)
    );

    always @(negedge clk) begin
        if (mv_a) begin
            mv_cnt = mv_cnt + 1;
            mv_val = meta_a;
        end
        if (to_a) to_cnt = to_cnt + 1;
        if (pos_a && neg_a) overlap = overlap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Rising edge on the chosen input, next rise lands exactly gap cycles later.
    task automatic pulse(input int which, input int gap);
        @(negedge clk);
        if (which == 0) din_a = 1'b1; else din_b = 1'b1;
        @(negedge clk);
        din_a = 1'b0;
        din_b = 1'b0;
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic frame(input int which, input int h0, input int l0, input int h1, input int l1,
                         input int h2, input int l2, input int h3, input int l3);
        repeat (3) pulse(which, 10);
        pulse(which, h0); pulse(which, l0);
        pulse(which, h1); pulse(which, l1);
        pulse(which, h2); pulse(which, l2);
        pulse(which, h3); pulse(which, l3);
        pulse(which, 8);
    endtask

    initial begin
        int mv0, to0;
        rst   = 1'b1;
        din_a = 1'b0;
        din_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", state_a, 0);
        chk("rst_meta", meta_a, 0);
        chk("rst_outs", {mv_a, scan_a, pos_a, neg_a, to_a}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Frame A: 40/20 -> 1, 20/40 -> 0, 30/10 -> 1, 10/30 -> 0 => 4'b0101
        mv0 = mv_cnt;
        frame(0, 40, 20, 20, 40, 30, 10, 10, 30);
        $display("frame A: meta_out=%0d state=%0d", meta_a, state_a);
        chk("A_meta", meta_a, 5);
        chk("A_mv_once", mv_cnt - mv0, 1);
        chk("A_mv_aligned", mv_val, 5);
        chk("A_state", state_a, 7);
        chk("A_scan_active", scan_a, 1);

        // scan_rem = 12: one edge enters SEND_POS, 12 more decrement to 0
        for (int k = 1; k <= 12; k++) begin
            pulse(0, 10);
            chk("scan_pos", pos_a, (k % 2 == 1) ? 1 : 0);
            chk("scan_neg", neg_a, (k % 2 == 0) ? 1 : 0);
        end
        chk("scan_last_state", state_a, 9);
        pulse(0, 10);
        $display("scan done: state=%0d coils=%0d%0d", state_a, pos_a, neg_a);
        chk("scan_end_state", state_a, 0);
        chk("scan_end_coils", {scan_a, pos_a, neg_a}, 0);

        // Timeout: two preamble edges then silence
        to0 = to_cnt;
        pulse(0, 10);
        pulse(0, 10);
        chk("to_in_preamble", state_a, 1);
        repeat (25) @(negedge clk);
        chk("to_not_early", to_cnt - to0, 0);
        repeat (55) @(negedge clk);
        $display("timeout: pulses=%0d state=%0d meta=%0d", to_cnt - to0, state_a, meta_a);
        chk("to_once", to_cnt - to0, 1);
        chk("to_state", state_a, 0);
        chk("to_meta_kept", meta_a, 5);

        // Equal phases decode as zeros; scan_rem = 2
        frame(0, 25, 25, 25, 25, 25, 25, 25, 25);
        $display("frame Z: meta_out=%0d", meta_a);
        chk("Z_meta", meta_a, 0);
        pulse(0, 10); chk("Z_pos", state_a, 8);
        pulse(0, 10); chk("Z_neg", state_a, 9);
        pulse(0, 10); chk("Z_idle", state_a, 0);

        // Reset during SEND_NEG
        frame(0, 40, 20, 20, 40, 30, 10, 10, 30);
        chk("R_meta_pre", meta_a, 5);
        pulse(0, 10);
        pulse(0, 10);
        chk("R_in_neg", {state_a, neg_a}, {4'd9, 1'b1});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        $display("mid-scan reset: state=%0d coil_neg=%0d meta=%0d", state_a, neg_a, meta_a);
        chk("R_state", state_a, 0);
        chk("R_coil_neg", neg_a, 0);
        chk("R_meta", meta_a, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Bit 1 high edge comes at the earliest possible moment after bit 0 closes
        // (END_BIT lasts one cycle, so two-cycle edge spacing is the tightest case).
        // 30/10 -> 1, 2/30 -> 0, 30/10 -> 1, 30/10 -> 1 => 4'b1101
        mv0 = mv_cnt;
        frame(0, 30, 10, 2, 30, 30, 10, 30, 10);
        $display("frame Q: meta_out=%0d", meta_a);
        chk("Q_meta", meta_a, 13);
        chk("Q_mv_once", mv_cnt - mv0, 1);
        chk("Q_mv_aligned", mv_val, 13);

        // Saturation: 5000-cycle ADD clamps acc at 2047, then 2000 down leaves 47 -> 1.
        // bit1 5000/2100 -> 0, 40/20 -> 1, 20/40 -> 0 => 4'b0101 (a wrapping acc gives 4)
        frame(1, 5000, 2000, 5000, 2100, 40, 20, 20, 40);
        $display("frame S: meta_out=%0d state=%0d", meta_b, state_b);
        chk("S_meta", meta_b, 5);
        chk("S_state", state_b, 7);

        chk("coil_exclusive", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
